// File: rtl/adc_reader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adc_reader_pkg: shared state encoding and helpers for adc_reader     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package adc_reader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        DRAIN = 3'd2,
        ABORT = 3'd3,
        FIN   = 3'd4
    } state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_fwft.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_fifo_fwft: first-word-fall-through FIFO with synchronous flush  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sync_fifo_fwft #(
    parameter int DN      = 16,
    parameter int FIFO_AW = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               push,
    input  logic               pop,
    input  logic [DN-1:0]      din,
    output logic [DN-1:0]      dout,
    output logic               empty,
    output logic               full,
    output logic [FIFO_AW:0]   level
);

    localparam logic [FIFO_AW:0] c_depth = {1'b1, {FIFO_AW{1'b0}}};

    logic [DN-1:0]      r_mem [0:(1 << FIFO_AW)-1];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == c_depth);
    assign level     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    // A pop frees the slot this cycle, so a push into a full FIFO is accepted alongside it.
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (FIFO_AW+1)'(1);
                2'b01:   r_count <= r_count - (FIFO_AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/adc_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adc_reader: burst read client streaming ADC ring-buffer samples out  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module adc_reader
    import adc_reader_pkg::*;
#(
    parameter int            AN      = 24,
    parameter int            DN      = 16,
    parameter int            BURST   = 8,
    parameter logic [AN-1:0] BASE    = 24'hf00000,
    parameter int            RING_AW = 19,
    parameter int            LW      = 16,
    parameter int            FIFO_AW = 5
) (
    input  logic               clkSYS,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [RING_AW-1:0] start_idx,
    input  logic [LW-1:0]      len,
    output logic               busy,
    output logic               done,
    output logic               overflow,
    input  logic [DN-1:0]      mem,
    input  logic               valid,
    output logic [AN-1:0]      addr,
    output logic [DN-1:0]      data,
    output logic               req,
    output logic               wr,
    input  logic               ack,
    output logic [DN-1:0]      out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [FIFO_AW:0]   level
);

    localparam int                 c_off_w    = clog2(BURST);
    localparam logic [RING_AW-1:0] c_off_mask = RING_AW'((1 << c_off_w) - 1);
    localparam logic [RING_AW-1:0] c_burst_p  = RING_AW'(BURST);
    localparam int                 c_ow       = FIFO_AW + 2;
    localparam int                 c_cw       = FIFO_AW + 3;
    localparam logic [c_ow-1:0]    c_burst_o  = c_ow'(BURST);
    localparam logic [c_cw-1:0]    c_burst_c  = c_cw'(BURST);
    localparam logic [c_cw-1:0]    c_depth    = c_cw'(1 << FIFO_AW);

    state_t              r_state;
    logic [RING_AW-1:0]  r_ptr;
    logic [LW-1:0]       r_reqs_left;
    logic [c_ow-1:0]     r_outstanding;
    logic                r_req;
    logic [AN-1:0]       r_addr;
    logic                r_busy;
    logic                r_done;
    logic                r_overflow;

    logic                w_ack_taken;
    logic                w_ret;
    logic                w_push;
    logic                w_pop;
    logic                w_flush;
    logic                w_empty;
    logic                w_full;
    logic [FIFO_AW:0]    w_level;
    logic [c_ow-1:0]     w_out_next;
    logic [c_cw-1:0]     w_free;
    logic [c_cw-1:0]     w_need;
    logic                w_credit_ok;

    assign w_ack_taken = r_req && ack;
    assign w_ret       = valid && (r_state != IDLE) && (r_outstanding != '0);
    assign w_push      = valid && ((r_state == RUN) || (r_state == DRAIN));
    assign w_pop       = !w_empty && out_ready;
    assign w_flush     = (r_state == ABORT) && (r_outstanding == '0);

    // Words already in flight are reserved in the FIFO, so a full burst can always land.
    assign w_free      = c_depth - c_cw'(w_level);
    assign w_need      = c_cw'(r_outstanding) + c_burst_c;
    assign w_credit_ok = (w_free >= w_need);

    always_comb begin
        w_out_next = r_outstanding;
        if (w_ack_taken) begin
            w_out_next = w_out_next + c_burst_o;
        end
        if (w_ret) begin
            w_out_next = w_out_next - c_ow'(1);
        end
    end

    always_ff @(posedge clkSYS) begin
        if (reset) begin
            r_state       <= IDLE;
            r_ptr         <= '0;
            r_reqs_left   <= '0;
            r_outstanding <= '0;
            r_req         <= 1'b0;
            r_addr        <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_done        <= 1'b0;
            r_outstanding <= w_out_next;
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
            // An ack coinciding with abort still consumed a request slot at the arbiter.
            if (w_ack_taken) begin
                r_ptr       <= r_ptr + c_burst_p;
                r_reqs_left <= r_reqs_left - LW'(1);
            end
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_ptr         <= start_idx & ~c_off_mask;
                        r_reqs_left   <= len;
                        r_outstanding <= '0;
                        r_busy        <= 1'b1;
                        r_state       <= (len == '0) ? FIN : RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        r_req   <= 1'b0;
                        r_state <= ABORT;
                    end else if (w_ack_taken) begin
                        r_req <= 1'b0;
                        if (r_reqs_left == LW'(1)) begin
                            r_state <= DRAIN;
                        end
                    end else if (!r_req && (r_reqs_left != '0) && w_credit_ok) begin
                        r_req  <= 1'b1;
                        r_addr <= BASE + AN'(r_ptr);
                    end
                end
                DRAIN: begin
                    if (abort) begin
                        r_state <= ABORT;
                    end else if ((r_outstanding == '0) && w_empty) begin
                        r_state <= FIN;
                    end
                end
                ABORT: begin
                    if (r_outstanding == '0) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                FIN: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    sync_fifo_fwft #(
        .DN      (DN),
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk   (clkSYS),
        .rst   (reset),
        .flush (w_flush),
        .push  (w_push),
        .pop   (w_pop),
        .din   (mem),
        .dout  (out_data),
        .empty (w_empty),
        .full  (w_full),
        .level (w_level)
    );

    assign busy      = r_busy;
    assign done      = r_done;
    assign overflow  = r_overflow;
    assign addr      = r_addr;
    assign req       = r_req;
    assign data      = '0;
    assign wr        = 1'b0;
    assign out_valid = !w_empty;
    assign level     = w_level;

endmodule
`default_nettype wire
